// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit blocks.
//   - FSM state encodings, 3 bits, kept as plain localparams so legacy
//     code that compares against raw codes keeps working.
//   - Parity-type selector values.
//   - Default bit period in system clock cycles.
package uart_pkg;

  // Receiver FSM states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  // Transmitter FSM states
  localparam logic [2:0] TX_ST_IDLE   = 3'd0;
  localparam logic [2:0] TX_ST_START  = 3'd1;
  localparam logic [2:0] TX_ST_DATA   = 3'd2;
  localparam logic [2:0] TX_ST_PARITY = 3'd3;
  localparam logic [2:0] TX_ST_STOP   = 3'd4;

  // parity_type input values
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int CLKS_PER_BIT_DEF = 20;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for an asynchronous single-bit input.
//   clk : destination clock
//   rst : asynchronous active-low reset; both flops load RST_VAL
//   d   : asynchronous input
//   q   : synchronised output, two clk edges behind d
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: UART serial-to-parallel receive stage, LSB first, with
// optional parity and mid-bit sampling driven by a cycle counter.
//   clk1        : system clock
//   rst         : asynchronous active-low reset
//   rx_serial   : asynchronous serial line, idles high
//   parity_type : 0 = even, 1 = odd; sampled at the parity bit
//   data_out    : last received word, updated with data_valid
//   data_valid  : one-cycle strobe when data_out/flags are updated
//   parity_err  : parity mismatch of the reported frame
//   frame_err   : stop bit of the reported frame was low
//   rx_busy     : FSM not in IDLE
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_LENGTH  = 8,
  parameter int PARITY_EN    = 0,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                   clk1,
  input  logic                   rst,
  input  logic                   rx_serial,
  input  logic                   parity_type,
  output logic [DATA_LENGTH-1:0] data_out,
  output logic                   data_valid,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   rx_busy
);

  localparam int CYC_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_LENGTH);
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [CYC_W-1:0] HALF_LAST = CYC_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_LENGTH - 1);

  function automatic logic expected_parity(input logic [DATA_LENGTH-1:0] w,
                                           input logic odd);
    return (^w) ^ odd;
  endfunction

  logic                   rxs;
  logic [2:0]             state;
  logic [CYC_W-1:0]       cyc_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_LENGTH-1:0] shift_reg;
  logic                   perr;
  logic                   stop_sample;
  logic                   frame_done;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk1),
    .rst (rst),
    .d   (rx_serial),
    .q   (rxs)
  );

  assign rx_busy = (state != ST_IDLE);

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cyc_cnt     <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      perr        <= 1'b0;
      stop_sample <= 1'b1;
      frame_done  <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      // Result registers update one edge after the stop sample; the FSM is
      // already back in IDLE by then, so a new start bit loses no cycles.
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      if (frame_done) begin
        data_out   <= shift_reg;
        data_valid <= 1'b1;
        parity_err <= (PARITY_EN != 0) ? perr : 1'b0;
        frame_err  <= ~stop_sample;
      end

      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state   <= ST_START;
            cyc_cnt <= '0;
          end
        end
        ST_START: begin
          // Re-check the line half a bit in: a high here was a glitch.
          if (cyc_cnt == HALF_LAST) begin
            cyc_cnt <= '0;
            if (!rxs) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt            <= '0;
            shift_reg[bit_cnt] <= rxs;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            perr    <= (rxs != expected_parity(shift_reg, parity_type));
            state   <= ST_STOP;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt     <= '0;
            stop_sample <= rxs;
            frame_done  <= 1'b1;
            state       <= rxs ? ST_IDLE : ST_BREAK;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          // Hold off until the line is released so a stuck-low line is not
          // mistaken for a stream of start bits.
          if (rxs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed bench for uart_receiver. Instance a is 8N1,
// instance b is 8 data bits plus parity; both run at 20 clocks per bit.
module tb_uart_receiver;

  localparam int CPB = 20;
  localparam int H   = CPB / 2;

  logic       clk1 = 1'b0;
  logic       rst  = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic       pt   = 1'b0;

  logic [7:0] data_a, data_b;
  logic       dv_a, dv_b, pe_a, pe_b, fe_a, fe_b, busy_a, busy_b;

  always #5 clk1 = ~clk1;

  uart_receiver #(.DATA_LENGTH(8), .PARITY_EN(0), .CLKS_PER_BIT(CPB)) u_a (
    .clk1        (clk1),
    .rst         (rst),
    .rx_serial   (rx_a),
    .parity_type (pt),
    .data_out    (data_a),
    .data_valid  (dv_a),
    .parity_err  (pe_a),
    .frame_err   (fe_a),
    .rx_busy     (busy_a)
  );

  uart_receiver #(.DATA_LENGTH(8), .PARITY_EN(1), .CLKS_PER_BIT(CPB)) u_b (
    .clk1        (clk1),
    .rst         (rst),
    .rx_serial   (rx_b),
    .parity_type (pt),
    .data_out    (data_b),
    .data_valid  (dv_b),
    .parity_err  (pe_b),
    .frame_err   (fe_b),
    .rx_busy     (busy_b)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk1) cyc <= cyc + 1;

  // Strobe logs, sampled on the falling edge.
  int         dv_cnt_a = 0, dv_cnt_b = 0;
  logic [7:0] log_data_a [64];
  logic       log_pe_a   [64];
  logic       log_fe_a   [64];
  int         log_cyc_a  [64];
  logic [7:0] log_data_b [64];
  logic       log_pe_b   [64];
  logic       log_fe_b   [64];

  always @(negedge clk1) begin
    if (dv_a) begin
      log_data_a[dv_cnt_a % 64] <= data_a;
      log_pe_a[dv_cnt_a % 64]   <= pe_a;
      log_fe_a[dv_cnt_a % 64]   <= fe_a;
      log_cyc_a[dv_cnt_a % 64]  <= cyc;
      dv_cnt_a                  <= dv_cnt_a + 1;
    end
    if (dv_b) begin
      log_data_b[dv_cnt_b % 64] <= data_b;
      log_pe_b[dv_cnt_b % 64]   <= pe_b;
      log_fe_b[dv_cnt_b % 64]   <= fe_b;
      dv_cnt_b                  <= dv_cnt_b + 1;
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  // Called just after a rising edge; leaves the caller just after a rising edge.
  task automatic drive_bit(input bit on_b, input logic b);
    if (on_b) rx_b = b;
    else      rx_a = b;
    repeat (CPB) @(posedge clk1);
    #1;
  endtask

  task automatic send_frame(input bit on_b, input logic [7:0] d,
                            input logic par_bit, input logic stop_bit);
    drive_bit(on_b, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(on_b, d[i]);
    if (on_b) drive_bit(on_b, par_bit);
    drive_bit(on_b, stop_bit);
  endtask

  typedef struct {
    bit         on_b;
    logic [7:0] data;
    logic       ptype;
    logic       par_bit;
    logic       stop_bit;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int n0, t_start, busy_n;

    //          on_b  data   ptype par   stop  exp_d  pe    fe
    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk1);
    #1;
    check("reset data_out", int'(data_a), 0);
    check("reset data_valid", int'(dv_a), 0);
    check("reset parity_err", int'(pe_b), 0);
    check("reset frame_err", int'(fe_a), 0);
    check("reset rx_busy", int'(busy_a | busy_b), 0);
    rst = 1'b1;
    repeat (5) @(posedge clk1);
    #1;

    // Table-driven frames, each followed by two idle bit times.
    for (int v = 0; v < 10; v++) begin
      pt      = vecs[v].ptype;
      n0      = vecs[v].on_b ? dv_cnt_b : dv_cnt_a;
      t_start = cyc;
      send_frame(vecs[v].on_b, vecs[v].data, vecs[v].par_bit, vecs[v].stop_bit);
      drive_bit(vecs[v].on_b, 1'b1);
      drive_bit(vecs[v].on_b, 1'b1);
      if (vecs[v].on_b) begin
        check($sformatf("v%0d strobes", v), dv_cnt_b - n0, 1);
        check($sformatf("v%0d data", v), int'(log_data_b[n0 % 64]), int'(vecs[v].exp_data));
        check($sformatf("v%0d parity_err", v), int'(log_pe_b[n0 % 64]), int'(vecs[v].exp_pe));
        check($sformatf("v%0d frame_err", v), int'(log_fe_b[n0 % 64]), int'(vecs[v].exp_fe));
        check($sformatf("v%0d data hold", v), int'(data_b), int'(vecs[v].exp_data));
      end else begin
        check($sformatf("v%0d strobes", v), dv_cnt_a - n0, 1);
        check($sformatf("v%0d data", v), int'(log_data_a[n0 % 64]), int'(vecs[v].exp_data));
        check($sformatf("v%0d parity_err", v), int'(log_pe_a[n0 % 64]), 0);
        check($sformatf("v%0d frame_err", v), int'(log_fe_a[n0 % 64]), int'(vecs[v].exp_fe));
        check($sformatf("v%0d data hold", v), int'(data_a), int'(vecs[v].exp_data));
        // Start bit driven after edge P0: edges P1,P2 synchronise, P3 leaves
        // IDLE, mid start at P3+H, stop sampled P3+H+9*CPB, strobe one edge
        // later: P0 + 3 + 10 + 180 + 1 = P0 + 194.
        if (v == 0)
          check("v0 strobe latency", log_cyc_a[n0 % 64] - t_start, 3 + H + 9 * CPB + 1);
      end
    end

    // Stop bit low, line held low three more bit times.
    n0 = dv_cnt_a;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
    repeat (3 * CPB) @(posedge clk1);
    #1;
    check("break strobes", dv_cnt_a - n0, 1);
    check("break data", int'(log_data_a[n0 % 64]), 8'h3C);
    check("break frame_err", int'(log_fe_a[n0 % 64]), 1);
    check("break busy held", int'(busy_a), 1);
    rx_a = 1'b1;
    repeat (5) @(posedge clk1);
    #1;
    check("break busy released", int'(busy_a), 0);
    repeat (2 * CPB) @(posedge clk1);
    #1;
    check("break no second frame", dv_cnt_a - n0, 1);

    // Five-cycle low glitch on the idle line.
    n0     = dv_cnt_a;
    busy_n = 0;
    rx_a   = 1'b0;
    repeat (5) @(posedge clk1);
    #1;
    rx_a = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk1);
      if (busy_a) busy_n++;
    end
    @(posedge clk1);
    #1;
    check("glitch busy seen", int'(busy_n > 0), 1);
    check("glitch busy <= H", int'(busy_n <= H), 1);
    check("glitch no strobe", dv_cnt_a - n0, 0);
    check("glitch idle", int'(busy_a), 0);

    // Back-to-back frames with no idle gap.
    n0 = dv_cnt_a;
    send_frame(1'b0, 8'h55, 1'b0, 1'b1);
    send_frame(1'b0, 8'hAA, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    check("b2b strobes", dv_cnt_a - n0, 2);
    check("b2b first data", int'(log_data_a[n0 % 64]), 8'h55);
    check("b2b second data", int'(log_data_a[(n0 + 1) % 64]), 8'hAA);
    check("b2b spacing", log_cyc_a[(n0 + 1) % 64] - log_cyc_a[n0 % 64], 10 * CPB);

    // Reset in the middle of the data bits, released while the line idles.
    n0 = dv_cnt_a;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    rst = 1'b0;
    #1;
    check("abort busy in reset", int'(busy_a), 0);
    check("abort data_out reset", int'(data_a), 0);
    rx_a = 1'b1;
    repeat (7 * CPB) @(posedge clk1);
    #1;
    rst = 1'b1;
    repeat (CPB) @(posedge clk1);
    #1;
    check("abort no strobe", dv_cnt_a - n0, 0);
    send_frame(1'b0, 8'h81, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    check("post-abort strobes", dv_cnt_a - n0, 1);
    check("post-abort data", int'(log_data_a[n0 % 64]), 8'h81);
    check("post-abort frame_err", int'(log_fe_a[n0 % 64]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
